ppbuf_reader: RTL
=================

PPBUF_READER -- requirements
Module: ppbuf_reader

Interface
REQ-001 Parameter BLOCK_LEN, 192, bits per bank block (one OFDM symbol of coded bits).
REQ-002 Parameter ADDR_W, 9, read address width.
REQ-003 Parameter COLS, 16, interleaver column count d; BLOCK_LEN SHALL be a multiple of COLS.
REQ-004 clk  in  1  single clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 bank_valid  in  2  level per bank, [0]=A, [1]=B: bank holds a complete block.
REQ-007 bank_release  out  2  one-cycle pulse per bank: bank fully consumed, writer may refill.
REQ-008 rdaddress  out  ADDR_W  shared read address to both banks.
REQ-009 rden_A, rden_B  out  1 each  read enables; at most one high per cycle.
REQ-010 q_A, q_B  in  1 each  bank read data, valid exactly one cycle after the matching rden.
REQ-011 data_out  out  1  serial output bit.
REQ-012 valid_out  out  1  data_out valid.
REQ-013 ready_in  in  1  downstream accept; transfer when valid_out && ready_in.

Function
REQ-014 FSM states: IDLE, READ (one active bank, selected by bank pointer), DONE (last read issued, awaiting capture).
REQ-015 IDLE -> READ when bank_valid[ptr] is high; the first read issues in the same cycle.
REQ-016 Banks are read in strict alternation A, B, A, ...; ptr toggles after the last read of each bank.
REQ-017 Read index k counts 0..BLOCK_LEN-1 per bank and wraps to 0 on bank switch.
REQ-018 After the last read, the block SHALL go directly to READ on the other bank with no bubble if that bank's bank_valid is high; otherwise it SHALL go to DONE, then IDLE.
REQ-019 Output path: a 2-entry skid FIFO captures q of the bank read in the previous cycle.
REQ-020 A read issues only when (FIFO count after this cycle's pop) + in-flight reads < 2; FIFO never overflows.
REQ-021 With ready_in held high and the next bank valid, throughput is 1 bit/clk continuously across bank boundaries.
REQ-022 valid_out = FIFO not empty; data_out = FIFO head; both are stable while valid_out && !ready_in.
REQ-023 bank_release[b] pulses in the cycle the last bit of bank b is captured into the FIFO.
REQ-024 rdaddress holds its last value when no read issues; rden_A/rden_B low when no read issues.
REQ-025 Simultaneous capture of the last bit and bank_valid deassertion: the release pulse is still issued.

Reset
REQ-026 On reset: state IDLE, ptr=A, k=0, FIFO flushed, in-flight cleared; rdaddress=0, rden_A=rden_B=0, valid_out=0, data_out=0, bank_release=0.
REQ-027 Reset mid-block discards the partial block with no bank_release pulse; after reset, reading restarts at bank A, k=0.

Configuration
REQ-028 Macro PPBUF_RD_INTERLEAVE_EN defined: rdaddress = (BLOCK_LEN/COLS)*(k mod COLS) + floor(k/COLS), the first IEEE 802.16 interleaver permutation.
REQ-029 Macro PPBUF_RD_INTERLEAVE_EN undefined: rdaddress = k (linear readout).
REQ-030 The permuted address is generated from incremental row/column counters, without multipliers or dividers.

Structure
REQ-031 Package ppbuf_pkg holds BLOCK_LEN, ADDR_W and COLS defaults, the FSM state enum, and the bank-index typedef.
REQ-032 Sub-module ppbuf_rd_addr_gen holds the k counter, the row/column counters, and the macro-selected address mapping.

Verification
REQ-033 Bank A valid, ready_in=1, linear build, bank A pattern = address LSB -> 192 bits 0,1,0,1..., rdaddress 0..191, bank_release[0] pulse once.
REQ-034 Interleave build, bank A valid -> rdaddress sequence starts 0,12,24,...,180,1,13 and ends with 191.
REQ-035 Banks A and B both valid, ready_in=1 -> 384 contiguous valid_out cycles, rden_B follows rden_A with no gap, release pulses [0] then [1].
REQ-036 ready_in random at 50% -> no bit lost or duplicated, data_out stable during stalls, rden never issued with FIFO full.
REQ-037 Reset asserted at k=100 of bank A -> all outputs reach their reset values asynchronously, no release pulse; after reset, the next read is bank A at rdaddress 0.
REQ-038 Only bank B valid after reset -> remains in IDLE with no rden until bank_valid[0] is asserted.

Source files
------------

// File: rtl/ppbuf_pkg.sv
// ppbuf_pkg: shared definitions for the ping-pong buffer reader.
//   - default block length, read address width and interleaver column count
//   - reader FSM state encoding
//   - bank index type (A = 0, B = 1)
// Build option: PPBUF_RD_INTERLEAVE_EN selects the permuted read address
// (consumed by ppbuf_rd_addr_gen).
package ppbuf_pkg;

  localparam int PPBUF_BLOCK_LEN = 192;
  localparam int PPBUF_ADDR_W    = 9;
  localparam int PPBUF_COLS      = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_DONE = 2'd2
  } rd_state_t;

  typedef logic bank_idx_t;

  localparam bank_idx_t BANK_A = 1'b0;
  localparam bank_idx_t BANK_B = 1'b1;

endpackage

// File: rtl/ppbuf_rd_addr_gen.sv
// ppbuf_rd_addr_gen: read index k and the bank address derived from it.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   adv        : a read issues this cycle; step k (wraps after the last read)
//   addr       : address for the current k
//   last       : current k is the last index of the block
// Build option PPBUF_RD_INTERLEAVE_EN:
//   defined   : addr = (BLOCK_LEN/COLS)*(k mod COLS) + floor(k/COLS), kept
//               incrementally with column/row counters (no multiply/divide)
//   undefined : addr = k
module ppbuf_rd_addr_gen
  import ppbuf_pkg::*;
#(
  parameter int BLOCK_LEN = PPBUF_BLOCK_LEN,
  parameter int ADDR_W    = PPBUF_ADDR_W,
  parameter int COLS      = PPBUF_COLS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              adv,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(BLOCK_LEN - 1);
  localparam logic [ADDR_W-1:0] K_ONE  = ADDR_W'(1);

  logic [ADDR_W-1:0] k_q, k_d;

  assign last = (k_q == K_LAST);

  always_comb begin
    k_d = k_q;
    if (adv) begin
      k_d = last ? '0 : k_q + K_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q <= '0;
    end else begin
      k_q <= k_d;
    end
  end

`ifdef PPBUF_RD_INTERLEAVE_EN
  localparam int                CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0]     COL_LAST = CW'(COLS - 1);
  localparam logic [CW-1:0]     COL_ONE  = CW'(1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(BLOCK_LEN / COLS);

  // col = k mod COLS, row = floor(k/COLS); paddr tracks ROWS*col + row.
  // Stepping k adds ROWS to the address, except when the column wraps,
  // where the address restarts at the next row number.
  logic [CW-1:0]     col_q, col_d;
  logic [ADDR_W-1:0] row_q, row_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    paddr_d = paddr_q;
    if (adv) begin
      if (last) begin
        col_d   = '0;
        row_d   = '0;
        paddr_d = '0;
      end else if (col_q == COL_LAST) begin
        col_d   = '0;
        row_d   = row_q + K_ONE;
        paddr_d = row_q + K_ONE;
      end else begin
        col_d   = col_q + COL_ONE;
        paddr_d = paddr_q + ROW_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q   <= '0;
      row_q   <= '0;
      paddr_q <= '0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      paddr_q <= paddr_d;
    end
  end

  assign addr = paddr_q;
`else
  assign addr = k_q;
`endif

endmodule

// File: rtl/ppbuf_reader.sv
// ppbuf_reader: drains two ping-pong bank RAMs (A, B) in strict alternation
// into a serial valid/ready bit stream.
// Ports:
//   clk, reset     : clock, asynchronous active-high reset
//   bank_valid[1:0]: bank holds a complete block ([0]=A, [1]=B)
//   bank_release   : one-cycle pulse when the last bit of a bank is captured
//   rdaddress      : shared read address (holds when no read issues)
//   rden_A, rden_B : bank read enables, at most one high
//   q_A, q_B       : bank read data, valid one cycle after the matching rden
//   data_out       : serial output bit (head of the 2-entry skid FIFO)
//   valid_out      : data_out valid
//   ready_in       : downstream accept
// Build option PPBUF_RD_INTERLEAVE_EN: permuted (interleaver) readout order,
// see ppbuf_rd_addr_gen; default build reads linearly.
module ppbuf_reader
  import ppbuf_pkg::*;
#(
  parameter int BLOCK_LEN = PPBUF_BLOCK_LEN,
  parameter int ADDR_W    = PPBUF_ADDR_W,
  parameter int COLS      = PPBUF_COLS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        bank_valid,
  output logic [1:0]        bank_release,
  output logic [ADDR_W-1:0] rdaddress,
  output logic              rden_A,
  output logic              rden_B,
  input  logic              q_A,
  input  logic              q_B,
  output logic              data_out,
  output logic              valid_out,
  input  logic              ready_in
);

  rd_state_t         state_q, state_d;
  bank_idx_t         ptr_q, ptr_d;
  logic              inflight_q;
  bank_idx_t         inflight_bank_q;
  logic              inflight_last_q;
  logic [ADDR_W-1:0] rdaddress_q;

  logic [1:0]        fifo_q, fifo_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              issue;
  logic              pop;
  logic              wr;
  logic              wr_bit;
  logic [1:0]        occ_after;
  logic              can_issue;
  logic [ADDR_W-1:0] gen_addr;
  logic              gen_last;

  ppbuf_rd_addr_gen #(
    .BLOCK_LEN (BLOCK_LEN),
    .ADDR_W    (ADDR_W),
    .COLS      (COLS)
  ) u_addr_gen (
    .clk   (clk),
    .reset (reset),
    .adv   (issue),
    .addr  (gen_addr),
    .last  (gen_last)
  );

  assign valid_out = (count_q != 2'd0);
  assign data_out  = fifo_q[rd_ptr_q];

  always_comb begin
    pop    = valid_out && ready_in;
    wr     = inflight_q;
    wr_bit = (inflight_bank_q == BANK_B) ? q_B : q_A;

    // Occupancy once this cycle's pop and capture have happened; a new read
    // lands one cycle later, so it may only go out if a slot is guaranteed.
    occ_after = count_q - {1'b0, pop} + {1'b0, wr};
    can_issue = (occ_after < 2'd2);

    state_d = state_q;
    ptr_d   = ptr_q;
    issue   = 1'b0;

    case (state_q)
      ST_IDLE, ST_READ: begin
        // The first read of a block goes out in the same cycle IDLE sees
        // its bank valid. Reset masks the combinational enable so the read
        // strobes drop immediately with the asynchronous reset.
        if (state_q == ST_READ || bank_valid[ptr_q]) begin
          state_d = ST_READ;
          issue   = can_issue && !reset;
          if (issue && gen_last) begin
            ptr_d   = ~ptr_q;
            state_d = bank_valid[~ptr_q] ? ST_READ : ST_DONE;
          end
        end
      end
      ST_DONE: begin
        // The final read of the block is captured during this cycle.
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    fifo_d = fifo_q;
    if (wr) begin
      fifo_d[wr_ptr_q] = wr_bit;
    end
    wr_ptr_d = wr_ptr_q ^ wr;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, wr} - {1'b0, pop};
  end

  assign rden_A    = issue && (ptr_q == BANK_A);
  assign rden_B    = issue && (ptr_q == BANK_B);
  assign rdaddress = issue ? gen_addr : rdaddress_q;

  // Release is decoded from the in-flight flags, so it coincides with the
  // capture of the last bit and does not depend on bank_valid any more.
  // A reset clears the flags, so a discarded partial block never releases.
  for (genvar gi = 0; gi < 2; gi++) begin : g_release
    assign bank_release[gi] = inflight_q && inflight_last_q &&
                              (inflight_bank_q == bank_idx_t'(gi));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      ptr_q           <= BANK_A;
      inflight_q      <= 1'b0;
      inflight_bank_q <= BANK_A;
      inflight_last_q <= 1'b0;
      rdaddress_q     <= '0;
      fifo_q          <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      ptr_q           <= ptr_d;
      inflight_q      <= issue;
      inflight_bank_q <= ptr_q;
      inflight_last_q <= issue && gen_last;
      rdaddress_q     <= rdaddress;
      fifo_q          <= fifo_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

endmodule
